mem_port_arbiter: RTL

Arbitrates one shared single-port, fixed-latency memory between the instruction-fetch stage (IF requester) and the data-memory stage (DM requester, lw/sw) of the 5-stage RISC-V pipeline.
- Grants one requester at a time, sequences the memory access with a latency counter, returns read data, and pulses an ack.
- Exports per-requester stall signals, which the pipeline uses to hold the PC or pipeline registers and to drive the Control unit's NoOP input.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_lat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEFAULT_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_lat_counter.sv
// Access latency down-counter: loaded on grant, raises done once it reaches zero.
module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int CNT_W = $clog2(DEFAULT_MEM_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Load on grant, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end
  end

  assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the data-memory stage; DM has fixed priority, IF fetches can be flushed.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  input  logic              flush_i,
  output logic              if_stall_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);

  state_e            state_r;
  owner_e            owner_r;
  logic              drop_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] dm_rdata_r;
  logic              if_ack_r;
  logic              dm_ack_r;

  logic              start_s;
  owner_e            grant_owner_s;
  logic              grant_we_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic [DATA_W-1:0] grant_wdata_s;
  logic              done_s;

  // Fixed-priority grant decision; flush only masks the IF request
  always_comb begin
    start_s       = 1'b0;
    grant_owner_s = OWN_IF;
    grant_we_s    = 1'b0;
    grant_addr_s  = if_addr_i;
    grant_wdata_s = {DATA_W{1'b0}};
    if (state_r == IDLE) begin
      if (dm_req_i) begin
        start_s       = 1'b1;
        grant_owner_s = OWN_DM;
        grant_we_s    = dm_we_i;
        grant_addr_s  = dm_addr_i;
        grant_wdata_s = dm_wdata_i;
      end else if (if_req_i && !flush_i) begin
        start_s = 1'b1;
      end else begin
        start_s = 1'b0;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  mem_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (start_s),
    .value (LAT_LOAD),
    .done  (done_s)
  );

  // Arbitration FSM: grant, hold the access fields, capture read data, pulse the ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      owner_r     <= OWN_IF;
      drop_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_rdata_r  <= {DATA_W{1'b0}};
      if_ack_r    <= 1'b0;
      dm_ack_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          drop_r   <= 1'b0;
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          if (start_s) begin
            state_r     <= BUSY;
            owner_r     <= grant_owner_s;
            mem_req_r   <= 1'b1;
            mem_we_r    <= grant_we_s;
            mem_addr_r  <= grant_addr_s;
            mem_wdata_r <= grant_wdata_s;
          end
        end
        BUSY: begin
          mem_req_r <= 1'b0;
          if (flush_i && owner_r == OWN_IF) begin
            drop_r <= 1'b1;
          end
          // A flushed fetch still lands in if_rdata, it just never acks
          if (done_s) begin
            state_r <= RESP;
            if (owner_r == OWN_DM) begin
              dm_ack_r <= 1'b1;
              if (!mem_we_r) begin
                dm_rdata_r <= mem_rdata_i;
              end
            end else begin
              if_rdata_r <= mem_rdata_i;
              if_ack_r   <= ~drop_r & ~flush_i;
            end
          end
        end
        RESP: begin
          state_r  <= IDLE;
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          drop_r   <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          if_ack_r  <= 1'b0;
          dm_ack_r  <= 1'b0;
          drop_r    <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack_o    = if_ack_r & ~flush_i;
  assign dm_ack_o    = dm_ack_r;
  assign if_rdata_o  = if_rdata_r;
  assign dm_rdata_o  = dm_rdata_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign if_stall_o  = if_req_i & ~if_ack_o;
  assign dm_stall_o  = dm_req_i & ~dm_ack_o;

endmodule
